// File: rtl/and3_sched_pkg.sv
// Shared types and constants for the and3 request scheduler.
package and3_sched_pkg;

  // Scheduler FSM states; the encoding is visible on a debug bus, so keep it fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Width of one requester's operand field, ordered {i3,i2,i1}.
  localparam int OPS_W  = 3;
  localparam int I1_BIT = 0;
  localparam int I2_BIT = 1;
  localparam int I3_BIT = 2;

endpackage

// File: rtl/and3_rr_arb.sv
// Combinational round-robin arbiter: the scan starts at ptr and ascends with
// wrap-around, and the first asserted request wins. Outputs are all zero when en is low.
module and3_rr_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);

  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

  // Walk NREQ positions starting at ptr and take the first requester found.
  always_comb begin
    logic [ID_W:0] pos;
    logic          found;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(i);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (en && !found && req[pos[ID_W-1:0]]) begin
        found                  = 1'b1;
        grant[pos[ID_W-1:0]]   = 1'b1;
        grant_idx              = pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/and3_sched.sv
// Shares one and3 datapath between NREQ requesters. The block accepts one
// operand triple per round-robin grant, waits out the and3 register stage, and
// returns the captured result on a tagged response channel.
module and3_sched #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [and3_sched_pkg::OPS_W*NREQ-1:0] req_ops,
  output logic [NREQ-1:0]               req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_data,
  output logic                          dp_i1,
  output logic                          dp_i2,
  output logic                          dp_i3,
  input  logic                          dp_o1,
  output logic                          busy,
  output logic [CNT_W-1:0]              op_count
);

  import and3_sched_pkg::*;

  localparam logic [ID_W:0] LAST_IDX = (ID_W+1)'(NREQ-1);

  state_e            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, ptr_nxt, grant_idx;
  logic [NREQ-1:0]   grant;
  logic [OPS_W-1:0]  ops_sel;
  logic              arb_en, accept, rsp_hs;

  // Grants are only offered from IDLE, and never while reset is held.
  assign arb_en = (state == IDLE) && !reset;

  and3_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign rsp_hs    = (state == RESP) && rsp_ready;
  assign busy      = (state != IDLE);
  assign ptr_nxt   = ({1'b0, grant_idx} == LAST_IDX) ? '0 : grant_idx + ID_W'(1);

  // Select the granted requester's operands; grant is one-hot so an OR-mux suffices.
  always_comb begin
    ops_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) ops_sel = ops_sel | req_ops[OPS_W*k +: OPS_W];
    end
  end

  // Next-state logic: one accept, two cycles of and3 latency, then hold for the consumer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; a reset mid-operation abandons the operation.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath drives, response capture, round-robin pointer and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      dp_i1     <= 1'b0;
      dp_i2     <= 1'b0;
      dp_i3     <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
      rsp_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        dp_i1  <= ops_sel[I1_BIT];
        dp_i2  <= ops_sel[I2_BIT];
        dp_i3  <= ops_sel[I3_BIT];
        rsp_id <= grant_idx;
        rr_ptr <= ptr_nxt;
      end
      if (state == WAIT) begin
        rsp_data  <= dp_o1;
        rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule
